// File: rtl/ntt_pu_ctrl.sv
// ntt_pu_ctrl: sequencing controller for a D-lane NTT/INTT processing unit.
// Accepts one transform job per input handshake. It loads the coefficient
// vector for one cycle, then steps the butterfly stage index through S
// compute cycles (upward for NTT, downward for INTT). It then holds the
// result valid until the consumer takes it.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid, in_inv     job request and job type (1 = inverse)
//   in_ready             controller can take a job this cycle (combinational)
//   load, en             PU register input select / clock enable
//   stage                butterfly stage index to PU twiddle/partner muxes
//   inv_q                latched job type to PU
//   busy                 job in flight
//   out_valid, out_ready result handshake
//   job_cnt              completed-job counter, saturating (only with NTT_PU_CTRL_PERF_EN)
//
// Optional feature macro: NTT_PU_CTRL_PERF_EN adds the job_cnt output.
module ntt_pu_ctrl #(
    parameter int unsigned D = 16,
    localparam int unsigned S = $clog2(D),
    localparam int unsigned SW = (S > 1) ? $clog2(S) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          in_inv,
    output logic          in_ready,
    output logic          load,
    output logic          en,
    output logic [SW-1:0] stage,
    output logic          inv_q,
    output logic          busy,
    output logic          out_valid,
`ifdef NTT_PU_CTRL_PERF_EN
    output logic [15:0]   job_cnt,
`endif
    input  logic          out_ready
);

    typedef enum logic [1:0] {IDLE, LOAD, COMP, DONE} state_t;

    localparam logic [SW-1:0] STAGE_LAST = SW'(S - 1);

    state_t        state;
    state_t        state_nx;
    logic [SW-1:0] stage_nx;
    logic          inv_nx;
    logic          in_hs;
    logic          out_hs;
    logic          terminal;

    // Handshake decode; in_ready is the only input-dependent output.
    always_comb begin
        in_ready = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
        in_hs    = in_valid && in_ready;
        out_hs   = (state == DONE) && out_ready;
        terminal = inv_q ? (stage == '0) : (stage == STAGE_LAST);
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_nx  = state;
        stage_nx  = stage;
        inv_nx    = inv_q;
        load      = 1'b0;
        en        = 1'b0;
        out_valid = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (in_hs) begin
                    state_nx = LOAD;
                    inv_nx   = in_inv;
                    stage_nx = in_inv ? STAGE_LAST : '0;
                end
            end
            LOAD: begin
                load     = 1'b1;
                en       = 1'b1;
                state_nx = COMP;
            end
            COMP: begin
                en = 1'b1;
                // Stage holds at its terminal value rather than wrapping.
                if (terminal) begin
                    state_nx = DONE;
                end else begin
                    stage_nx = inv_q ? (stage - SW'(1)) : (stage + SW'(1));
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_hs) begin
                    // A job accepted in the same cycle goes straight to LOAD.
                    if (in_hs) begin
                        state_nx = LOAD;
                        inv_nx   = in_inv;
                        stage_nx = in_inv ? STAGE_LAST : '0;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, stage index and job type registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            stage <= '0;
            inv_q <= 1'b0;
        end else begin
            state <= state_nx;
            stage <= stage_nx;
            inv_q <= inv_nx;
        end
    end

`ifdef NTT_PU_CTRL_PERF_EN
    // Completed-job counter, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            job_cnt <= 16'h0000;
        end else if (out_hs && (job_cnt != 16'hFFFF)) begin
            job_cnt <= job_cnt + 16'h0001;
        end
    end
`endif

endmodule
